dmem_responder: RTL and testbench

Data-memory responder for the single-cycle 54-instruction CPU. It serves the CPU's `DM_*` bus: combinational word reads, and word writes committed on the clock edge. It holds the word array, sweeps it to zero after reset, and flags out-of-range accesses. A second read-only debug port lets the bench or monitor inspect memory without disturbing the CPU.

---
 rtl/dmem_responder.sv | 116 +++++++++++
 tb/tb_dmem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the single-cycle CPU DM_* bus.
// Reads are combinational and writes commit on the rising edge. Out-of-range
// accesses raise a sticky flag. A debug port gives read-only access.
// Optional feature macro: DMEM_CLEAR_EN. When it is defined, a CLEAR/READY
// sweep zeroes the array after every reset and holds busy high meanwhile.
module dmem_responder #(
  parameter int          ADDR_W   = 11,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DM_ena,
  input  logic              DM_wena,
  input  logic              DM_rena,
  input  logic [31:0]       DM_addr,
  input  logic [31:0]       DM_data_in,
  output logic [31:0]       DM_data_out,
  output logic              busy,
  output logic              err,
  output logic [31:0]       err_addr,
  output logic [15:0]       wr_count,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              wr_en;
  logic              oor_hit;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  // The read strobe is informational; reads are always driven.
  logic              unused_rena;

  assign unused_rena = DM_rena;

  // Saturating increment for the write counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign in_range = (DM_addr[31:ADDR_W] == '0);
  assign idx      = DM_addr[ADDR_W-1:0];
  assign wr_en    = DM_ena & DM_wena & in_range & ~busy & ~rst;
  assign oor_hit  = DM_ena & ~in_range & ~busy & ~rst;

`ifdef DMEM_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clearing;

  // Sweep state register and clear pointer; a reset restarts the sweep from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (clearing) clr_ptr <= clr_ptr + 1'b1;
    end
  end

  // Next-state logic: one word is cleared per cycle until the last index.
  always_comb begin
    state_nxt = state;
    clearing  = 1'b0;
    case (state)
      CLEAR: begin
        clearing = 1'b1;
        if (clr_ptr == '1) state_nxt = READY;
      end
      READY:   state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  assign busy    = rst | clearing;
  assign clr_we  = clearing & ~rst;
  assign clr_idx = clr_ptr;
`else
  assign busy    = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
`endif

  // Word array: the sweep clear and CPU writes never coincide, since busy blocks the CPU.
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_idx] <= '0;
    else if (wr_en) mem[idx] <= DM_data_in;
  end

  // Error capture and write counting; the first offending address is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      err_addr <= '0;
      wr_count <= '0;
    end else begin
      if (wr_en) wr_count <= sat_inc16(wr_count);
      if (oor_hit) begin
        err <= 1'b1;
        if (!err) err_addr <= DM_addr;
      end
    end
  end

  assign DM_data_out = (in_range & ~busy) ? mem[idx] : ERR_DATA;
  assign dbg_data    = mem[dbg_addr];

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed steps plus a randomized phase.
// Expected values come from an array model of the memory and the error and
// counter rules. The bench follows the DMEM_CLEAR_EN build setting.
module tb_dmem_responder;
  localparam int          ADDR_W = 11;
  localparam int          DEPTH  = 2048;
  localparam logic [31:0] ERR    = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              rst;
  logic              DM_ena, DM_wena, DM_rena;
  logic [31:0]       DM_addr, DM_data_in, DM_data_out;
  logic              busy, err;
  logic [31:0]       err_addr;
  logic [15:0]       wr_count;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_data;

  int ntest = 0;
  int nfail = 0;

  // reference model state
  logic [31:0] mm [DEPTH];
  bit          m_err;
  logic [31:0] m_eaddr;
  int          m_cnt;

  dmem_responder #(.ADDR_W(ADDR_W), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst), .DM_ena(DM_ena), .DM_wena(DM_wena), .DM_rena(DM_rena),
    .DM_addr(DM_addr), .DM_data_in(DM_data_in), .DM_data_out(DM_data_out),
    .busy(busy), .err(err), .err_addr(err_addr), .wr_count(wr_count),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    DM_ena = 1'b0; DM_wena = 1'b0; DM_rena = 1'b0;
    DM_addr = 32'h0; DM_data_in = 32'h0;
  endtask

  task automatic model_reset_regs();
    m_err = 1'b0; m_eaddr = 32'h0; m_cnt = 0;
  endtask

  task automatic model_zero_mem();
    for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_err"},      {31'h0, err}, {31'h0, m_err});
    chk({tag, "_err_addr"}, err_addr, m_eaddr);
    chk({tag, "_wr_count"}, {16'h0, wr_count}, 32'(m_cnt));
  endtask

  // One serviced CPU cycle: optional read/debug checks mid-cycle, then model update.
  task automatic cyc(input bit ena, input bit we, input logic [31:0] addr,
                     input logic [31:0] data, input bit do_chk);
    logic [31:0] exp_rd;
    DM_ena = ena; DM_wena = we; DM_rena = ena;
    DM_addr = addr; DM_data_in = data;
    dbg_addr = ADDR_W'($urandom);
    #2;
    if (do_chk) begin
      exp_rd = (addr < DEPTH) ? mm[addr % DEPTH] : ERR;
      chk("rd_data", DM_data_out, exp_rd);
      chk("dbg_data", dbg_data, mm[dbg_addr]);
    end
    tick();
    if (ena && addr < DEPTH && we) begin
      mm[addr % DEPTH] = data;
      if (m_cnt < 65535) m_cnt++;
    end
    if (ena && addr >= DEPTH) begin
      if (!m_err) m_eaddr = addr;
      m_err = 1'b1;
    end
  endtask

  // Count cycles with busy high after reset release; DM_data_out must stay ERR_DATA.
  task automatic sweep_wait(output int n, output int bad);
    n = 0; bad = 0;
    DM_addr = 32'h5;
    while (busy === 1'b1 && n < 4000) begin
      #2;
      if (DM_data_out !== ERR) bad++;
      tick();
      n++;
    end
  endtask

  initial begin
    int n, bad, drops;
    logic [31:0] d, a, last;
    rst = 1'b1;
    idle();
    dbg_addr = '0;
    tick();
    tick();
    model_reset_regs();
    chk_regs("reset");
`ifdef DMEM_CLEAR_EN
    chk("reset_busy", {31'h0, busy}, 32'h1);
    chk("reset_rd_err", DM_data_out, ERR);
    // first sweep with blocked accesses, then a reset at sweep cycle 1000
    rst = 1'b0;
    drops = 0;
    for (int c = 1; c < 1000; c++) begin
      idle();
      if (c == 10) begin
        DM_ena = 1'b1; DM_wena = 1'b1; DM_addr = 32'h3; DM_data_in = 32'hAAAA5555;
      end
      if (c == 20) begin
        DM_ena = 1'b1; DM_wena = 1'b1; DM_addr = 32'h900; DM_data_in = 32'h1;
      end
      #2;
      if (busy !== 1'b1) drops++;
      if (c == 10) chk("blocked_rd", DM_data_out, ERR);
      tick();
    end
    idle();
    rst = 1'b1;
    #2;
    if (busy !== 1'b1) drops++;
    tick();
    chk("midsweep_busy_drops", 32'(drops), 32'h0);
    rst = 1'b0;
    sweep_wait(n, bad);
    chk("midsweep_len", 32'(n), 32'(DEPTH));
    chk("midsweep_rd_err", 32'(bad), 32'h0);
    idle();
    model_zero_mem();
    dbg_addr = 11'd3;
    #2;
    chk("blocked_mem3", dbg_data, 32'h0);
    chk_regs("after_sweep");
`else
    chk("reset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    DM_addr = 32'h900;
    #2;
    chk("oor_rd_err", DM_data_out, ERR);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 32'(i), 32'h0, 1'b0);
    chk_regs("init_fill");
`endif

    // write/read with same-cycle old-data semantics
    DM_ena = 1'b1; DM_wena = 1'b1; DM_rena = 1'b1;
    DM_addr = 32'h7; DM_data_in = 32'hCAFEF00D;
    #2;
    chk("wr7_same_cycle_old", DM_data_out, 32'h0);
    tick();
    mm[7] = 32'hCAFEF00D; m_cnt++;
    idle();
    DM_addr = 32'h7;
    #2;
    chk("wr7_next_cycle", DM_data_out, 32'hCAFEF00D);
    chk_regs("wr7");
`ifdef DMEM_CLEAR_EN
    chk("wr7_count_one", {16'h0, wr_count}, 32'h1);
`endif

    // out-of-range writes: first offender kept, nothing stored
    cyc(1'b1, 1'b1, 32'h00000800, 32'h11111111, 1'b1);
    cyc(1'b1, 1'b1, 32'h00001000, 32'h22222222, 1'b1);
    chk("oor_err", {31'h0, err}, 32'h1);
    chk("oor_err_addr", err_addr, 32'h00000800);
    chk_regs("oor");
    dbg_addr = '0;
    #2;
    chk("oor_no_alias", dbg_data, mm[0]);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 15) == 0) ? (32'h800 + $urandom_range(0, 32'h7FFFF)) : 32'($urandom_range(0, 63));
      cyc(($urandom_range(0, 3) != 0), 1'($urandom), a, $urandom, 1'b1);
      if (i % 50 == 49) chk_regs("rand");
    end

    // reset pulse: sweep clears memory (or memory survives without the sweep)
    cyc(1'b1, 1'b1, 32'h5, 32'h12345678, 1'b0);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset_regs();
`ifdef DMEM_CLEAR_EN
    sweep_wait(n, bad);
    chk("clear_len", 32'(n), 32'(DEPTH));
    chk("clear_rd_err", 32'(bad), 32'h0);
    model_zero_mem();
    idle();
    dbg_addr = 11'd5;
    #2;
    chk("clear_mem5", dbg_data, 32'h0);
`else
    #2;
    chk("noclear_busy", {31'h0, busy}, 32'h0);
    dbg_addr = 11'd5;
    #2;
    chk("noclear_mem5", dbg_data, 32'h12345678);
`endif
    chk_regs("after_rst");

    // saturation: 65537 writes to address 0
    last = 32'h0;
    for (int i = 0; i < 65537; i++) begin
      d = $urandom;
      last = d;
      cyc(1'b1, 1'b1, 32'h0, d, 1'b0);
      if (i == 65534) chk("sat_reach", {16'h0, wr_count}, 32'h0000FFFF);
    end
    chk("sat_hold", {16'h0, wr_count}, 32'h0000FFFF);
    chk_regs("sat");
    idle();
    dbg_addr = '0;
    #2;
    chk("sat_last_dbg", dbg_data, last);
    chk("sat_last_rd", DM_data_out, last);

    // an out-of-range access during reset does not set err
    DM_ena = 1'b1; DM_wena = 1'b1; DM_addr = 32'h00000800;
    rst = 1'b1;
    tick();
    chk("rst_beats_err", {31'h0, err}, 32'h0);
    chk("rst_flush_count", {16'h0, wr_count}, 32'h0);
    idle();

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
